// File: rtl/act_outlier_dispatch.sv
// act_outlier_dispatch
//   Streaming pre-stage in front of the mixed-precision PE array. Each
//   fixed-point activation is classified against +/-(THRESHOLD<<FRAC_W).
//   Inliers are rounded (half-up) and saturated to INT_W for the integer lane.
//   The first M outliers of a vector are forwarded raw, with their index,
//   through a small FIFO to the FP lane. Any further outliers are saturated
//   into the integer lane. After VEC_LEN elements a summary beat reports the
//   outlier count and whether it exceeded M.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   activation handshake, in_data = signed fixed point
//   q_valid/q_ready     integer-lane beat: q_data, q_idx, q_flag, q_sat
//   o_valid/o_ready     outlier FIFO head: o_data (raw), o_idx
//   s_valid/s_ready     vector summary: s_count, s_excess
module act_outlier_dispatch #(
  parameter  int DATA_W    = 32,
  parameter  int FRAC_W    = 8,
  parameter  int INT_W     = 8,
  parameter  int VEC_LEN   = 128,
  parameter  int THRESHOLD = 100,
  parameter  int M         = 4,
  localparam int IDX_W     = $clog2(VEC_LEN),
  localparam int CNT_W     = $clog2(VEC_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [INT_W-1:0]  q_data,
  output logic [IDX_W-1:0]  q_idx,
  output logic              q_flag,
  output logic              q_sat,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_idx,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [CNT_W-1:0]  s_count,
  output logic              s_excess
);

  localparam int FPTR_W = (M > 1) ? $clog2(M) : 1;
  localparam int FCNT_W = $clog2(M + 1);

  // All arithmetic is done one bit wider than the activation so that the
  // most-negative input and the rounding add cannot overflow.
  localparam logic signed [DATA_W:0] TH_POS   = (DATA_W+1)'(longint'(THRESHOLD) << FRAC_W);
  localparam logic signed [DATA_W:0] TH_NEG   = -TH_POS;
  localparam logic signed [DATA_W:0] RND_HALF = (DATA_W+1)'(longint'(1) << (FRAC_W - 1));
  localparam logic signed [DATA_W:0] QMAX_X   = (DATA_W+1)'((longint'(1) << (INT_W - 1)) - 1);
  localparam logic signed [DATA_W:0] QMIN_X   = -QMAX_X - 1;
  localparam logic [INT_W-1:0]       Q_POS    = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0]       Q_NEG    = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic {ST_STREAM, ST_SUMMARY} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_q_valid;
  logic [INT_W-1:0]  r_q_data;
  logic [IDX_W-1:0]  r_q_idx;
  logic              r_q_flag;
  logic              r_q_sat;

  logic [DATA_W-1:0] r_fmem_d [M];
  logic [IDX_W-1:0]  r_fmem_i [M];
  logic [FPTR_W-1:0] r_wptr;
  logic [FPTR_W-1:0] r_rptr;
  logic [FCNT_W-1:0] r_fcnt;

  logic                     w_accept;
  logic                     w_last;
  logic                     w_s_hs;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_is_out;
  logic                     w_room;
  logic signed [DATA_W:0]   w_x;
  logic signed [DATA_W:0]   w_sum;
  logic signed [DATA_W:0]   w_shr;
  logic [INT_W-1:0]         w_q_in;
  logic [INT_W-1:0]         w_q_next;

  // ---------------------------------------------------------------------
  // Classification and quantization of the element on in_data
  // ---------------------------------------------------------------------
  assign w_x      = {in_data[DATA_W-1], in_data};
  assign w_is_out = (w_x > TH_POS) || (w_x < TH_NEG);
  assign w_sum    = w_x + RND_HALF;
  assign w_shr    = w_sum >>> FRAC_W;

  always_comb begin
    w_q_in = w_shr[INT_W-1:0];
    if (w_shr > QMAX_X) begin
      w_q_in = Q_POS;
    end else if (w_shr < QMIN_X) begin
      w_q_in = Q_NEG;
    end
  end

  // r_cnt is the number of outliers seen before the current element, so
  // room in the FP lane means this outlier is among the first M.
  assign w_room = (r_cnt < CNT_W'(M));

  always_comb begin
    w_q_next = w_q_in;
    if (w_is_out) begin
      if (w_room) begin
        w_q_next = '0;
      end else begin
        // Outliers are never zero, so the sign bit alone decides x>0.
        w_q_next = in_data[DATA_W-1] ? Q_NEG : Q_POS;
      end
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDX_W'(VEC_LEN - 1));
  assign w_s_hs   = s_valid && s_ready;
  assign w_full   = (r_fcnt == FCNT_W'(M));
  assign w_push   = w_accept && w_is_out && w_room;
  assign w_pop    = o_valid && o_ready;

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STREAM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STREAM:  if (w_accept && w_last) w_state_nxt = ST_SUMMARY;
      ST_SUMMARY: if (s_ready)            w_state_nxt = ST_STREAM;
      default:                            w_state_nxt = ST_STREAM;
    endcase
  end

  // A full outlier FIFO stalls input even for inliers; this keeps the
  // push path free of any full check.
  always_comb begin
    in_ready = 1'b0;
    s_valid  = 1'b0;
    case (r_state)
      ST_STREAM:  in_ready = (!r_q_valid || q_ready) && !w_full;
      ST_SUMMARY: s_valid  = 1'b1;
      default:    ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Element index and per-vector outlier count
  // ---------------------------------------------------------------------
  // The index holds at VEC_LEN-1 after the last element and is cleared
  // together with the count when the summary is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (w_s_hs) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_is_out && (r_cnt != CNT_W'(VEC_LEN))) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Integer lane output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid <= 1'b0;
      r_q_data  <= '0;
      r_q_idx   <= '0;
      r_q_flag  <= 1'b0;
      r_q_sat   <= 1'b0;
    end else if (w_accept) begin
      r_q_valid <= 1'b1;
      r_q_data  <= w_q_next;
      r_q_idx   <= r_idx;
      r_q_flag  <= w_is_out && w_room;
      r_q_sat   <= w_is_out && !w_room;
    end else if (q_ready) begin
      r_q_valid <= 1'b0;
    end
  end

  assign q_valid = r_q_valid;
  assign q_data  = r_q_data;
  assign q_idx   = r_q_idx;
  assign q_flag  = r_q_flag;
  assign q_sat   = r_q_sat;

  // ---------------------------------------------------------------------
  // Outlier FIFO (circular buffer, depth M)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == FPTR_W'(M - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == FPTR_W'(M - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while the count says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fmem_d[r_wptr] <= in_data;
      r_fmem_i[r_wptr] <= r_idx;
    end
  end

  assign o_valid = (r_fcnt != '0);
  assign o_data  = o_valid ? r_fmem_d[r_rptr] : '0;
  assign o_idx   = o_valid ? r_fmem_i[r_rptr] : '0;

  // ---------------------------------------------------------------------
  // Summary outputs, qualified by s_valid
  // ---------------------------------------------------------------------
  assign s_count  = s_valid ? r_cnt : '0;
  assign s_excess = s_valid && (r_cnt > CNT_W'(M));

endmodule

// File: doc/act_outlier_dispatch.md
Name: act_outlier_dispatch

Overview:
- Streaming pre-stage directly upstream of the mixed-precision PE array.
- Takes fixed-point activations one element per beat and classifies each against a magnitude threshold.
- Inliers are quantized to INT_W signed integers for the integer MAC lane. Up to M outliers per vector are routed, unmodified with their index, to a small FP-lane FIFO. Excess outliers are saturated into the integer lane.
- After each VEC_LEN-element vector, emits a summary beat: outlier count and excess flag.

Parameters:
- DATA_W, 32, activation word width (signed fixed point).
- FRAC_W, 8, fractional bits of the activation word.
- INT_W, 8, quantized inlier width (signed).
- VEC_LEN, 128, elements per vector.
- THRESHOLD, 100, integer outlier threshold; compared as THRESHOLD<<FRAC_W.
- M, 4, max FP-lane outliers per vector; also the outlier FIFO depth.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  activation valid
- in_ready  out  1  activation accepted when in_valid&&in_ready
- in_data  in  DATA_W  signed fixed-point activation
- q_valid  out  1  integer-lane beat valid
- q_ready  in  1  integer-lane consumer ready
- q_data  out  INT_W  quantized value (0 for FP-routed outliers)
- q_idx  out  clog2(VEC_LEN)  element index within vector
- q_flag  out  1  element routed to FP lane
- q_sat  out  1  element was an excess outlier, saturated
- o_valid  out  1  outlier FIFO head valid
- o_ready  in  1  FP-lane pop
- o_data  out  DATA_W  raw outlier activation
- o_idx  out  clog2(VEC_LEN)  outlier element index
- s_valid  out  1  vector summary valid
- s_ready  in  1  summary consumer ready
- s_count  out  clog2(VEC_LEN+1)  total outliers in vector, excess included
- s_excess  out  1  s_count > M

Behaviour:
- Reset (async, rst_n=0):
  - All valids 0; q_data, q_idx, q_flag, q_sat, o_data, o_idx, s_count, s_excess all 0.
  - Element index 0, per-vector outlier count 0, FIFO empty, FSM in STREAM.
- Reset mid-vector discards the partial vector and all FIFO contents.
- FSM has two states, STREAM and SUMMARY.
  - STREAM to SUMMARY on acceptance of element index VEC_LEN-1.
  - SUMMARY to STREAM on s_valid&&s_ready; the index and count clear on that same edge.
  - in_ready=0 in SUMMARY.
- Outlier test: x > (THRESHOLD<<FRAC_W) or x < -(THRESHOLD<<FRAC_W), strict, signed compare. The most-negative input is handled without abs overflow.
- Inlier quantization:
  - q = (x + 2^(FRAC_W-1)) >>> FRAC_W, i.e. round-half-up. Computed in DATA_W+1 bits.
  - Then saturate to [-2^(INT_W-1), 2^(INT_W-1)-1]; q_sat stays 0 for inliers.
- Outlier with per-vector count < M: push {x, idx} into FIFO; q_data=0, q_flag=1, q_sat=0.
- Outlier with count >= M: nothing is pushed. q_data = +2^(INT_W-1)-1 if x>0, else -2^(INT_W-1); q_flag=0, q_sat=1.
- The count increments for every outlier and saturates at VEC_LEN.
- in_ready in STREAM = (!q_valid || q_ready) && !(FIFO full).
  - This is conservative: a full FIFO from the previous vector stalls all input.
- Integer lane:
  - Registered, one-cycle latency from acceptance to q_valid.
  - q_* holds stable while q_valid&&!q_ready.
- Outlier FIFO:
  - o_* reflects the head.
  - Push and pop in the same cycle are legal; a push into a full FIFO cannot occur, by construction of in_ready.
  - The FIFO drains independently of the FSM.
- Summary:
  - s_valid rises the cycle after the last element is accepted and holds until s_ready.
  - The last q beat and s_valid may be asserted together.

Test Plan:
- Inlier rounding: in_data=0x00000180 (1.5), then 0xFFFFFE80 (-1.5), then 0x00006400 (100.0) -> q_data=2, -1, 100; q_flag=0; o_valid stays 0.
- Threshold edge: in_data=0x00006401 (100.004) -> q_flag=1, q_data=0; FIFO pushes o_data=0x00006401 with o_idx equal to that element's index.
- Excess outliers: one vector with outliers at idx 3,10,20,30,40,50 (values +200.0, -300.0 at idx 50) -> first four go to FIFO; idx 40 gives q_data=127, q_sat=1; idx 50 gives q_data=-128, q_sat=1; summary s_count=6, s_excess=1.
- Backpressure: o_ready=0 with 4 outliers in vector 1 -> in_ready=0 during vector 2 until one pop; q_ready toggling every other cycle -> no lost or duplicated beat, q_idx sequence 0..127 exact.
- Summary handshake: hold s_ready=0 for 10 cycles after idx 127 -> in_ready=0, s_valid held; on s_ready=1 the next vector starts at q_idx=0 with count 0.
- Reset mid-operation: assert rst_n=0 at element 64 with 2 FIFO entries -> all valids 0 immediately; after release o_valid=0 and the first q_idx=0.
